bp_update_ctrl: RTL and testbench

- Sequences branch-resolution updates into the branch-prediction cache (2 async read ports, 1 sync write port; valid bit and tag handled inside the cache).
- Execute stage pushes resolved branches {pc, taken} into a small FIFO.
- The controller drains the FIFO with a read-modify-write of a 2-bit saturating counter. It uses the cache's second read port and its write port; the first read port stays dedicated to fetch.

---
 rtl/bp_update_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_bp_update_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bp_update_ctrl
//  Purpose  : Queues resolved-branch updates from execute and applies them to
//             the branch-prediction cache as a read-modify-write of a
//             saturating counter. Uses cache read port 2 and the write port;
//             read port 1 is left to fetch.
//  Ports    :
//    clk, reset                  clock, asynchronous active-high reset
//    upd_valid/upd_ready         update handshake (ready = FIFO not full)
//    upd_pc, upd_taken           resolved branch PC and outcome
//    flush                       drop all queued and in-flight updates
//    cache_ra                    read address to cache read port 2
//    cache_dout, cache_hit       read data / hit from cache read port 2
//    cache_wa, cache_din         write address / data (0 when not writing)
//    cache_we                    cache write enable
//    busy                        FIFO non-empty or sequencer active
//    upd_count                   committed cache writes, wraps at 2^16
//  Revision : 1.0 - initial release
// ============================================================================
module bp_update_ctrl #(
    parameter int AWIDTH = 32,
    parameter int CWIDTH = 2,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [AWIDTH-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic              flush,
    output logic [AWIDTH-1:0] cache_ra,
    input  logic [CWIDTH-1:0] cache_dout,
    input  logic              cache_hit,
    output logic [AWIDTH-1:0] cache_wa,
    output logic [CWIDTH-1:0] cache_din,
    output logic              cache_we,
    output logic              busy,
    output logic [15:0]       upd_count
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = PTRW + 1;

    localparam logic [CNTW-1:0]   c_full    = CNTW'(DEPTH);
    localparam logic [CWIDTH-1:0] c_ctr_max = {CWIDTH{1'b1}};
    localparam logic [CWIDTH-1:0] c_ctr_min = '0;
    // Weakly-taken is the MSB alone; weakly-not-taken is one below it.
    localparam logic [CWIDTH-1:0] c_weak_t  = CWIDTH'(1) << (CWIDTH - 1);
    localparam logic [CWIDTH-1:0] c_weak_nt = c_weak_t - CWIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_WRITE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] pc_mem_q [DEPTH];
    logic [AWIDTH-1:0] pc_mem_d [DEPTH];
    logic              tk_mem_q [DEPTH];
    logic              tk_mem_d [DEPTH];
    logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]   count_q,  count_d;
    logic [CWIDTH-1:0] nxt_ctr_q, nxt_ctr_d;
    logic [15:0]       upd_count_q, upd_count_d;

    logic              w_full;
    logic              w_enq;
    logic              w_deq;
    logic [AWIDTH-1:0] w_head_pc;
    logic              w_head_tk;
    logic [CNTW-1:0]   w_count_new;

    // ------------------------------------------------------------------
    // FIFO control. Full blocks enqueue even when a pop happens in the
    // same cycle, so upd_ready never depends on the sequencer state.
    // ------------------------------------------------------------------
    always_comb begin
        w_full      = (count_q == c_full);
        w_enq       = upd_valid && !w_full && !flush;
        w_deq       = (state_q == ST_WRITE);
        w_head_pc   = pc_mem_q[rd_ptr_q];
        w_head_tk   = tk_mem_q[rd_ptr_q];
        w_count_new = count_q - CNTW'(w_deq) + CNTW'(w_enq);
    end

    always_comb begin
        pc_mem_d = pc_mem_q;
        tk_mem_d = tk_mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_enq) begin
                pc_mem_d[wr_ptr_q] = upd_pc;
                tk_mem_d[wr_ptr_q] = upd_taken;
                wr_ptr_d           = wr_ptr_q + PTRW'(1);
            end
            if (w_deq) begin
                rd_ptr_d = rd_ptr_q + PTRW'(1);
            end
            count_d = w_count_new;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: LOOKUP reads the head entry, WRITE commits and pops.
    // The write lands on the WRITE->LOOKUP edge, so a following update to
    // the same PC reads the fresh counter without any forwarding.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        nxt_ctr_d   = nxt_ctr_q;
        upd_count_d = upd_count_q;
        cache_ra    = '0;
        cache_wa    = '0;
        cache_din   = '0;
        cache_we    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                cache_ra = w_head_pc;
                if (cache_hit) begin
                    if (w_head_tk) begin
                        nxt_ctr_d = (cache_dout == c_ctr_max) ? cache_dout
                                                              : cache_dout + CWIDTH'(1);
                    end else begin
                        nxt_ctr_d = (cache_dout == c_ctr_min) ? cache_dout
                                                              : cache_dout - CWIDTH'(1);
                    end
                end else begin
                    nxt_ctr_d = w_head_tk ? c_weak_t : c_weak_nt;
                end
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                cache_we    = 1'b1;
                cache_wa    = w_head_pc;
                cache_din   = nxt_ctr_q;
                // A write already on the port commits even under flush.
                upd_count_d = upd_count_q + 16'd1;
                state_d     = (w_count_new != '0) ? ST_LOOKUP : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_mem_q    <= '{default: '0};
            tk_mem_q    <= '{default: 1'b0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            nxt_ctr_q   <= '0;
            upd_count_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_mem_q    <= pc_mem_d;
            tk_mem_q    <= tk_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            nxt_ctr_q   <= nxt_ctr_d;
            upd_count_q <= upd_count_d;
        end
    end

    assign upd_ready = !w_full;
    assign busy      = (count_q != '0) || (state_q != ST_IDLE);
    assign upd_count = upd_count_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bp_update_ctrl
//  Purpose  : Self-checking bench for bp_update_ctrl with a direct-mapped
//             cache environment and a queue/map reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bp_update_ctrl;

    localparam int AW    = 32;
    localparam int CW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          upd_valid;
    logic          upd_ready;
    logic [AW-1:0] upd_pc;
    logic          upd_taken;
    logic          flush;
    logic [AW-1:0] cache_ra;
    logic [CW-1:0] cache_dout;
    logic          cache_hit;
    logic [AW-1:0] cache_wa;
    logic [CW-1:0] cache_din;
    logic          cache_we;
    logic          busy;
    logic [15:0]   upd_count;

    bp_update_ctrl #(.AWIDTH(AW), .CWIDTH(CW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .flush      (flush),
        .cache_ra   (cache_ra),
        .cache_dout (cache_dout),
        .cache_hit  (cache_hit),
        .cache_wa   (cache_wa),
        .cache_din  (cache_din),
        .cache_we   (cache_we),
        .busy       (busy),
        .upd_count  (upd_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- cache environment (direct mapped, 16 sets) ----------
    logic [CW-1:0] c_val [16];
    logic          c_vld [16];
    logic [AW-1:0] c_tag [16];
    logic          pre_en = 1'b0;
    logic [AW-1:0] pre_pc = '0;
    logic [CW-1:0] pre_val = '0;

    assign cache_dout = c_val[cache_ra[5:2]];
    assign cache_hit  = c_vld[cache_ra[5:2]] && (c_tag[cache_ra[5:2]] == cache_ra);

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                c_vld[i] <= 1'b0;
                c_val[i] <= '0;
                c_tag[i] <= '0;
            end
        end else if (cache_we) begin
            c_val[cache_wa[5:2]] <= cache_din;
            c_vld[cache_wa[5:2]] <= 1'b1;
            c_tag[cache_wa[5:2]] <= cache_wa;
        end else if (pre_en) begin
            c_val[pre_pc[5:2]] <= pre_val;
            c_vld[pre_pc[5:2]] <= 1'b1;
            c_tag[pre_pc[5:2]] <= pre_pc;
        end
    end

    // ---------------- reference model ------------------------------------
    typedef struct {
        logic [AW-1:0] pc;
        logic          tk;
    } upd_t;

    upd_t          mq[$];
    int            ref_ctr [logic [AW-1:0]];
    int            n_wr = 0;
    logic [CW-1:0] obs_din[$];

    function automatic int predict(input logic [AW-1:0] pc, input logic tk);
        int v;
        if (ref_ctr.exists(pc)) begin
            v = ref_ctr[pc];
            if (tk) return (v >= 3) ? 3 : v + 1;
            else    return (v <= 0) ? 0 : v - 1;
        end
        return tk ? 2 : 1;
    endfunction

    // Everything sampled on the falling edge describes what the next
    // rising edge will do.
    always @(negedge clk) begin
        upd_t e;
        int   exp_v;
        if (reset) begin
            mq.delete();
            ref_ctr.delete();
            obs_din.delete();
            n_wr = 0;
        end else begin
            chk("upd_count", 64'(upd_count), 64'(16'(n_wr)));
            chk("upd_ready", 64'(upd_ready), 64'(mq.size() < DEPTH));
            chk("busy", 64'(busy), 64'(mq.size() != 0));
            if (pre_en) ref_ctr[pre_pc] = int'(pre_val);
            if (cache_we) begin
                if (mq.size() == 0) begin
                    chk("unexpected_we", 64'(cache_we), 64'(0));
                end else begin
                    e     = mq.pop_front();
                    exp_v = predict(e.pc, e.tk);
                    chk("cache_wa", 64'(cache_wa), 64'(e.pc));
                    chk("cache_din", 64'(cache_din), 64'(exp_v));
                    ref_ctr[e.pc] = exp_v;
                    obs_din.push_back(cache_din);
                end
                n_wr++;
            end else begin
                chk("idle_wa_din", {30'd0, cache_wa, cache_din}, 64'(0));
            end
            if (flush) mq.delete();
            else if (upd_valid && upd_ready) mq.push_back('{pc: upd_pc, tk: upd_taken});
        end
    end

    // ---------------- driver helpers -------------------------------------
    int stalls = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        upd_valid = 1'b0;
        upd_pc    = '0;
        upd_taken = 1'b0;
        flush     = 1'b0;
        reset     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic send(input logic [AW-1:0] pc, input logic tk);
        logic acc;
        int   t;
        t         = 0;
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_taken = tk;
        forever begin
            @(negedge clk);
            acc = upd_ready;
            tick();
            if (acc) break;
            stalls++;
            t++;
            if (t > 50) begin
                chk("send_timeout", 64'(1), 64'(0));
                break;
            end
        end
        upd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 200) begin
            tick();
            t++;
        end
        chk("idle_timeout", 64'(busy), 64'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we"},    64'(cache_we),  64'(0));
        chk({tag, "_ra"},    64'(cache_ra),  64'(0));
        chk({tag, "_wa"},    64'(cache_wa),  64'(0));
        chk({tag, "_din"},   64'(cache_din), 64'(0));
        chk({tag, "_busy"},  64'(busy),      64'(0));
        chk({tag, "_ready"}, 64'(upd_ready), 64'(1));
        chk({tag, "_count"}, 64'(upd_count), 64'(0));
    endtask

    // ---------------- stimulus -------------------------------------------
    initial begin
        logic [CW-1:0] exp_seq[$];
        int            t;

        upd_valid = 1'b0;
        upd_pc    = '0;
        upd_taken = 1'b0;
        flush     = 1'b0;
        reset     = 1'b1;
        #1;
        chk_reset_outputs("rst");
        do_reset();

        // Single update on a miss: write appears in the third cycle.
        upd_valid = 1'b1;
        upd_pc    = 32'h0000_1000;
        upd_taken = 1'b1;
        tick();
        upd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("lat_we_%0d", k), 64'(cache_we), 64'(k == 3));
            if (k == 3) begin
                chk("lat_wa", 64'(cache_wa), 64'h1000);
                chk("lat_din", 64'(cache_din), 64'(2'b10));
            end
            tick();
        end
        chk("single_count", 64'(upd_count), 64'(1));
        chk("single_busy", 64'(busy), 64'(0));

        // Saturation on one PC, then a not-taken step down.
        do_reset();
        for (int i = 0; i < 4; i++) send(32'h40, 1'b1);
        send(32'h40, 1'b0);
        wait_idle();
        exp_seq = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b10};
        chk("sat_len", 64'(obs_din.size()), 64'(5));
        for (int i = 0; i < 5 && i < obs_din.size(); i++)
            chk($sformatf("sat_din_%0d", i), 64'(obs_din[i]), 64'(exp_seq[i]));

        // Floor saturation on a hit, weak not-taken on a miss.
        do_reset();
        pre_en  = 1'b1;
        pre_pc  = 32'h80;
        pre_val = 2'b00;
        tick();
        pre_en = 1'b0;
        send(32'h80, 1'b0);
        send(32'h84, 1'b0);
        wait_idle();
        chk("floor_len", 64'(obs_din.size()), 64'(2));
        if (obs_din.size() == 2) begin
            chk("floor_din", 64'(obs_din[0]), 64'(2'b00));
            chk("miss_nt_din", 64'(obs_din[1]), 64'(2'b01));
        end

        // Back-to-back offers fill the FIFO and get held off.
        do_reset();
        stalls = 0;
        for (int i = 0; i < 8; i++) send(32'h100 + 32'(4 * i), 1'(i % 2));
        wait_idle();
        chk("full_stall_seen", 64'(stalls > 0), 64'(1));
        chk("full_all_written", 64'(upd_count), 64'(8));

        // Flush with three queued entries while in LOOKUP.
        do_reset();
        for (int i = 0; i < 4; i++) send(32'h200 + 32'(4 * i), 1'b1);
        chk("flush_pre_count", 64'(upd_count), 64'(1));
        chk("flush_pre_lookup", 64'(cache_ra), 64'h204);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'(0));
        chk("flush_ready", 64'(upd_ready), 64'(1));
        for (int k = 0; k < 6; k++) begin
            chk("flush_no_we", 64'(cache_we), 64'(0));
            tick();
        end
        chk("flush_count", 64'(upd_count), 64'(1));

        // Asynchronous reset in the middle of a WRITE cycle.
        do_reset();
        send(32'h300, 1'b1);
        t = 0;
        while (!cache_we && t < 20) begin
            tick();
            t++;
        end
        chk("mid_write_reached", 64'(cache_we), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outputs("async");
        tick();
        reset = 1'b0;
        tick();

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            upd_valid = 1'($urandom_range(0, 1));
            upd_pc    = 32'h100 + 32'(4 * $urandom_range(0, 7));
            upd_taken = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        upd_valid = 1'b0;
        flush     = 1'b0;
        wait_idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
